// File: rtl/stopwatch_timer_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_timer_core_if
//  Purpose  : Button/switch inputs and display/status outputs of the
//             stopwatch core, bundled with master (board side) and slave
//             (core side) views.
//  Revision : 1.0  initial release
// ============================================================================
interface stopwatch_timer_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    b;
    logic                    lap;
    logic [1:0]              mode;
    logic [4*NUM_DIGITS-1:0] preset;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    running;
    logic                    done;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              sseg;

    modport master (
        output b, lap, mode, preset,
        input  count, running, done, an, sseg
    );

    modport slave (
        input  b, lap, mode, preset,
        output count, running, done, an, sseg
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_timer_core
//  Purpose  : N-digit BCD stopwatch/countdown with start/stop, lap freeze,
//             terminal-count detect and multiplexed active-low 7-seg drive.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_timer_core #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 1000000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    stopwatch_timer_core_if.slave bus
);
    localparam int c_W  = 4 * NUM_DIGITS;
    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_RW = $clog2(REFRESH_DIV);
    localparam int c_IW = $clog2(NUM_DIGITS);
    localparam logic [c_PW-1:0] c_TICK_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_RW-1:0] c_REF_MAX  = c_RW'(REFRESH_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_MAX  = c_IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_b_q;
    logic            r_lap_q;
    logic            r_down;
    logic            r_freeze;
    logic [c_W-1:0]  r_count;
    logic [c_W-1:0]  r_lap_val;
    logic [c_PW-1:0] r_presc;
    logic [c_RW-1:0] r_ref;
    logic [c_IW-1:0] r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]      r_sseg;

    logic            w_b_press;
    logic            w_lap_press;
    logic            w_tick;
    logic            w_carry;
    logic [c_W-1:0]  w_load;
    logic [c_W-1:0]  w_step;
    logic [c_W-1:0]  w_disp;
    logic [3:0]      w_digit;
    logic [NUM_DIGITS-1:0] w_an;
    logic [6:0]      w_seg;

    // Terminal is all zeros when counting down, all nines when counting up.
    function automatic logic f_terminal(input logic [c_W-1:0] v, input logic down);
        logic all9;
        all9 = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
        return down ? (v == '0) : all9;
    endfunction

    assign w_b_press   = bus.b & ~r_b_q;
    assign w_lap_press = bus.lap & ~r_lap_q;
    assign w_tick      = (r_state == S_RUN) && (r_presc == c_TICK_MAX);
    assign w_disp      = r_freeze ? r_lap_val : r_count;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            case (bus.mode)
                2'b00:   w_load[4*i +: 4] = 4'd0;
                2'b10:   w_load[4*i +: 4] = 4'd9;
                default: w_load[4*i +: 4] = (bus.preset[4*i +: 4] > 4'd9) ? 4'd9
                                                                          : bus.preset[4*i +: 4];
            endcase
        end
    end

    // One-step BCD increment/decrement with ripple carry/borrow.
    always_comb begin
        w_step  = r_count;
        w_carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (r_down) begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_step[4*i +: 4] = 4'd9;
                    end else begin
                        w_step[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] >= 4'd9) begin
                        w_step[4*i +: 4] = 4'd0;
                    end else begin
                        w_step[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_b_press)
                         w_state_next = f_terminal(w_load, bus.mode[1]) ? S_DONE : S_RUN;
            S_RUN:   if (w_b_press)
                         w_state_next = S_PAUSE;
                     else if (w_tick && f_terminal(w_step, r_down))
                         w_state_next = S_DONE;
            S_PAUSE: if (w_b_press) w_state_next = S_RUN;
            S_DONE:  if (w_b_press) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b_q     <= 1'b0;
            r_lap_q   <= 1'b0;
            r_down    <= bus.mode[1];
            r_count   <= w_load;
            r_presc   <= '0;
            r_freeze  <= 1'b0;
            r_lap_val <= '0;
        end else begin
            r_b_q   <= bus.b;
            r_lap_q <= bus.lap;
            if (r_state == S_IDLE) r_down <= bus.mode[1];

            // A press coinciding with a tick pauses without stepping.
            if (r_state == S_IDLE || w_state_next == S_IDLE)
                r_count <= w_load;
            else if (r_state == S_RUN && !w_b_press && w_tick)
                r_count <= w_step;

            if (w_state_next == S_RUN) begin
                if (r_state != S_RUN || w_tick) r_presc <= '0;
                else                            r_presc <= r_presc + 1'b1;
            end

            if (w_state_next == S_IDLE || w_state_next == S_DONE) begin
                r_freeze <= 1'b0;
            end else if (w_lap_press && (r_state == S_RUN || r_state == S_PAUSE)) begin
                r_freeze <= ~r_freeze;
                if (!r_freeze) r_lap_val <= r_count;
            end
        end
    end

    always_comb begin
        w_digit = '0;
        w_an    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_digit = w_disp[4*i +: 4];
                w_an[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_digit)
            4'd0: w_seg = 7'h40;
            4'd1: w_seg = 7'h79;
            4'd2: w_seg = 7'h24;
            4'd3: w_seg = 7'h30;
            4'd4: w_seg = 7'h19;
            4'd5: w_seg = 7'h12;
            4'd6: w_seg = 7'h02;
            4'd7: w_seg = 7'h78;
            4'd8: w_seg = 7'h00;
            4'd9: w_seg = 7'h10;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref  <= '0;
            r_idx  <= '0;
            r_an   <= '1;
            r_sseg <= 7'h7F;
        end else begin
            if (r_ref == c_REF_MAX) begin
                r_ref <= '0;
                r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_ref <= r_ref + 1'b1;
            end
            r_an   <= w_an;
            r_sseg <= w_seg;
        end
    end

    assign bus.count   = r_count;
    assign bus.running = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.an      = r_an;
    assign bus.sseg    = r_sseg;
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_timer_core
//  Purpose  : Directed vector bench for stopwatch_timer_core (4 digits,
//             tick every 2 clocks, digit slot every 4 clocks).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_timer_core;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    stopwatch_timer_core_if #(.NUM_DIGITS(4)) bus ();

    stopwatch_timer_core #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (2),
        .REFRESH_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        b;
        logic        lap;
        logic [1:0]  mode;
        logic [15:0] preset;
        logic [15:0] exp_count;
        logic        exp_running;
        logic        exp_done;
    } vec_t;

    vec_t tbl[$];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic press();
        bus.b = 1'b1;
        cyc(1);
        bus.b = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [15:0] p);
        bus.mode   = m;
        bus.preset = p;
        bus.b      = 1'b0;
        bus.lap    = 1'b0;
        reset      = 1'b1;
        cyc(1);
        reset      = 1'b0;
    endtask

    function automatic logic [3:0] seg2dig(input logic [6:0] s);
        case (s)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    // Watch one full scan and rebuild the shown number from an/sseg.
    task automatic capture(output logic [15:0] shown);
        shown = 16'hFFFF;
        repeat (20) begin
            cyc(1);
            for (int i = 0; i < 4; i++)
                if (bus.an == ~(4'b0001 << i)) shown[4*i +: 4] = seg2dig(bus.sseg);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] shown;
        n_vec = 0;
        n_err = 0;

        // rst b lap mode preset  count running done
        tbl.push_back('{0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 0});
        tbl.push_back('{0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h0000, 16'h0001, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h0000, 16'h0001, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h0000, 16'h0002, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h0000, 16'h0002, 1, 0});
        tbl.push_back('{1, 0, 0, 2'b11, 16'h0003, 16'h0003, 0, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0003, 0, 0});
        tbl.push_back('{0, 1, 0, 2'b11, 16'h0003, 16'h0003, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0003, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0002, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0002, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0001, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0001, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0000, 0, 1});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0003, 16'h0000, 0, 1});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h1234, 16'h0000, 0, 1});
        tbl.push_back('{0, 1, 0, 2'b11, 16'h0003, 16'h0003, 0, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0000, 16'h0000, 0, 0});
        tbl.push_back('{0, 1, 0, 2'b11, 16'h0000, 16'h0000, 0, 1});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h0000, 16'h0000, 0, 1});
        tbl.push_back('{0, 1, 0, 2'b11, 16'h0000, 16'h0000, 0, 0});
        tbl.push_back('{0, 0, 0, 2'b01, 16'h9AF3, 16'h9993, 0, 0});
        tbl.push_back('{0, 0, 0, 2'b10, 16'h0000, 16'h9999, 0, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h9999, 16'h0000, 0, 0});
        tbl.push_back('{0, 0, 0, 2'b01, 16'h9999, 16'h9999, 0, 0});
        tbl.push_back('{0, 1, 0, 2'b01, 16'h9999, 16'h9999, 0, 1});
        tbl.push_back('{0, 0, 0, 2'b01, 16'h9999, 16'h9999, 0, 1});
        tbl.push_back('{0, 1, 0, 2'b11, 16'h1000, 16'h1000, 0, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h1000, 16'h1000, 0, 0});
        tbl.push_back('{0, 1, 0, 2'b11, 16'h1000, 16'h1000, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h1000, 16'h1000, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 16'h1000, 16'h0999, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h0000, 16'h0999, 1, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 16'h0000, 16'h0998, 1, 0});

        reset      = 1'b1;
        bus.b      = 1'b0;
        bus.lap    = 1'b0;
        bus.mode   = 2'b00;
        bus.preset = 16'h0000;
        @(negedge clk);
        check("reset count",   bus.count,   16'h0000);
        check("reset running", bus.running, 1'b0);
        check("reset done",    bus.done,    1'b0);
        check("reset an",      bus.an,      4'hF);
        check("reset sseg",    bus.sseg,    7'h7F);
        bus.mode   = 2'b11;
        bus.preset = 16'h00A3;
        cyc(1);
        check("reset load clamp", bus.count, 16'h0093);
        bus.mode   = 2'b00;
        bus.preset = 16'h0000;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("idle count", bus.count, 16'h0000);

        foreach (tbl[k]) begin
            reset      = tbl[k].rst;
            bus.b      = tbl[k].b;
            bus.lap    = tbl[k].lap;
            bus.mode   = tbl[k].mode;
            bus.preset = tbl[k].preset;
            cyc(1);
            check($sformatf("vec%0d count", k),   bus.count,   tbl[k].exp_count);
            check($sformatf("vec%0d running", k), bus.running, tbl[k].exp_running);
            check($sformatf("vec%0d done", k),    bus.done,    tbl[k].exp_done);
        end

        // Up count through the decade carry
        do_reset(2'b00, 16'h0000);
        press();
        check("t1 running", bus.running, 1'b1);
        cyc(19);
        check("t1 count 9", bus.count, 16'h0009);
        cyc(1);
        check("t1 count 10", bus.count, 16'h0010);

        // Pause/resume, and press on a tick edge
        do_reset(2'b00, 16'h0000);
        press();
        cyc(10);
        check("t3 count 5", bus.count, 16'h0005);
        press();
        check("t3 paused running", bus.running, 1'b0);
        cyc(20);
        check("t3 frozen count", bus.count, 16'h0005);
        check("t3 frozen running", bus.running, 1'b0);
        press();
        check("t3 resumed running", bus.running, 1'b1);
        check("t3 resume count", bus.count, 16'h0005);
        cyc(2);
        check("t3 count 6", bus.count, 16'h0006);
        cyc(1);
        press();
        check("t3 press-on-tick count", bus.count, 16'h0006);
        check("t3 press-on-tick running", bus.running, 1'b0);

        // Lap freeze and release
        do_reset(2'b00, 16'h0000);
        press();
        cyc(8);
        check("t4 count 4", bus.count, 16'h0004);
        bus.lap = 1'b1;
        cyc(1);
        bus.lap = 1'b0;
        cyc(9);
        check("t4 count 9", bus.count, 16'h0009);
        capture(shown);
        check("t4 frozen display", shown, 16'h0004);
        check("t4 live count", bus.count, 16'h0019);
        press();
        check("t4 paused count", bus.count, 16'h0019);
        bus.lap = 1'b1;
        cyc(1);
        bus.lap = 1'b0;
        capture(shown);
        check("t4 live display", shown, 16'h0019);

        // Up from preset to all-nines, no wrap, reload on press
        do_reset(2'b01, 16'h9997);
        check("t5 load", bus.count, 16'h9997);
        press();
        cyc(2);
        check("t5 count 9998", bus.count, 16'h9998);
        cyc(2);
        check("t5 count 9999", bus.count, 16'h9999);
        check("t5 done", bus.done, 1'b1);
        cyc(6);
        check("t5 no wrap", bus.count, 16'h9999);
        press();
        check("t5 reload", bus.count, 16'h9997);
        check("t5 done cleared", bus.done, 1'b0);

        // Asynchronous reset mid-run and scan order afterwards
        do_reset(2'b00, 16'h0000);
        press();
        cyc(14);
        check("t6 count 7", bus.count, 16'h0007);
        reset = 1'b1;
        #1;
        check("t6 async an", bus.an, 4'hF);
        check("t6 async sseg", bus.sseg, 7'h7F);
        check("t6 async count", bus.count, 16'h0000);
        check("t6 async running", bus.running, 1'b0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("t6 an slot0", bus.an, 4'b1110);
        check("t6 sseg zero", bus.sseg, 7'h40);
        cyc(4);
        check("t6 an slot1", bus.an, 4'b1101);
        cyc(4);
        check("t6 an slot2", bus.an, 4'b1011);
        cyc(4);
        check("t6 an slot3", bus.an, 4'b0111);
        cyc(4);
        check("t6 an wrap", bus.an, 4'b1110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
